// File: rtl/gactx_result_if.sv
// gactx_result_if: tile/direction input stream and packed-beat output handshake of the result packer
interface gactx_result_if #(parameter int NUM_DIR_BLOCK = 64);
  logic [511:0] tile_in;
  logic tile_done;
  logic [31:0] dir_count;
  logic [2*NUM_DIR_BLOCK-1:0] dir_in;
  logic dir_valid;
  logic [511:0] m_data;
  logic m_last;
  logic m_valid;
  logic m_ready;
  modport master (input tile_in, tile_done, dir_count, dir_in, dir_valid, m_ready,
                  output m_data, m_last, m_valid);
  modport slave (output tile_in, tile_done, dir_count, dir_in, dir_valid, m_ready,
                 input m_data, m_last, m_valid);
endinterface

// File: rtl/gactx_result_packer.sv
// gactx_result_packer: packs a tile header plus streamed direction words into 512-bit beats behind a FWFT FIFO
module gactx_result_packer #(
  parameter int NUM_DIR_BLOCK = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int LOG_FIFO_DEPTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  gactx_result_if.master bus,
  output logic busy,
  output logic overflow,
  output logic proto_err,
  output logic [LOG_FIFO_DEPTH:0] fifo_level
);
  localparam int DW = 2*NUM_DIR_BLOCK;
  localparam int DPB = 512/DW;
  localparam int SW = DPB > 1 ? $clog2(DPB) : 1;
  typedef enum logic [1:0] {IDLE, HDR, COLLECT} state_t;
  state_t state, state_nxt;
  logic [511:0] header, pack, pack_nxt, wr_data;
  logic [31:0] remaining, rem_dec;
  logic [SW-1:0] slot;
  logic wr_en, wr_last, beat_done, wr_ok, rd_en, full;
  logic [512:0] mem [FIFO_DEPTH];
  logic [LOG_FIFO_DEPTH-1:0] wr_ptr, rd_ptr;
  assign rem_dec = remaining - 32'd1;
  assign full = fifo_level == (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      header <= '0;
      remaining <= '0;
      pack <= '0;
      slot <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.tile_done) begin
        header <= bus.tile_in;
        remaining <= bus.dir_count;
        pack <= '0;
        slot <= '0;
      end
      if (state == COLLECT && bus.dir_valid) begin
        remaining <= rem_dec;
        pack <= beat_done ? '0 : pack_nxt;
        slot <= beat_done ? '0 : slot + SW'(1);
      end
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.tile_done ? HDR : IDLE;
      HDR: state_nxt = remaining == 0 ? IDLE : COLLECT;
      COLLECT: state_nxt = bus.dir_valid && rem_dec == 0 ? IDLE : COLLECT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    pack_nxt = pack;
    pack_nxt[slot*DW +: DW] = bus.dir_in;
    beat_done = slot == SW'(DPB-1) || rem_dec == 0;
    wr_en = state == HDR || (state == COLLECT && bus.dir_valid && beat_done);
    wr_data = state == HDR ? header : pack_nxt;
    wr_last = state == HDR ? remaining == 0 : rem_dec == 0;
  end
  // Flags are sticky; a new error in the same cycle as clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      overflow <= (wr_en && full) | (overflow & ~clear);
      proto_err <= (bus.tile_done && state != IDLE) | (bus.dir_valid && state != COLLECT) | (proto_err & ~clear);
    end
  end
  // Fullness is judged before the read, so a same-cycle pop never makes room
  assign wr_ok = wr_en && !full;
  assign rd_en = bus.m_valid && bus.m_ready;
  always_ff @(posedge clk) if (wr_ok) mem[wr_ptr] <= {wr_last, wr_data};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr <= wr_ptr + LOG_FIFO_DEPTH'(wr_ok);
      rd_ptr <= rd_ptr + LOG_FIFO_DEPTH'(rd_en);
      fifo_level <= fifo_level + (LOG_FIFO_DEPTH+1)'(wr_ok) - (LOG_FIFO_DEPTH+1)'(rd_en);
    end
  end
  assign bus.m_valid = fifo_level != 0;
  assign {bus.m_last, bus.m_data} = bus.m_valid ? mem[rd_ptr] : '0;
endmodule

// File: doc/gactx_result_packer.md
# gactx_result_packer

Downstream stage of the GACT-X array wrapper. It captures the 512-bit tile result word on `done_GACT`, then collects the streamed 128-bit traceback direction words. It packs everything into 512-bit beats in a first-word-fall-through output FIFO, which is drained by the host/DMA write path through a valid/ready handshake. The array wrapper cannot be back-pressured, so the packer buffers, and it flags loss instead of stalling.

## Interface
Parameters:
- `NUM_DIR_BLOCK`, 64: direction word width is 2*NUM_DIR_BLOCK bits; 512 must be a multiple of it.
- `FIFO_DEPTH`, 64: output FIFO entries (power of two, ≥4).
- `LOG_FIFO_DEPTH`, 6: log2(FIFO_DEPTH).

Derived constant: DPB = 512/(2*NUM_DIR_BLOCK) direction words per beat (4 at default).

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `clear`  in  1  synchronous pulse; clears sticky flags
- `tile_in`  in  512  tile result word, valid while `tile_done`=1
- `tile_done`  in  1  one-cycle pulse; tile result available
- `dir_count`  in  32  number of direction words to follow, valid with `tile_done`
- `dir_in`  in  2*NUM_DIR_BLOCK  direction word
- `dir_valid`  in  1  one-cycle qualifier for `dir_in`
- `m_data`  out  512  FIFO head beat
- `m_last`  out  1  head beat is the final beat of its tile
- `m_valid`  out  1  FIFO non-empty
- `m_ready`  in  1  consumer accepts the head beat this cycle
- `busy`  out  1  state ≠ IDLE
- `overflow`  out  1  sticky; a beat was dropped because the FIFO was full
- `proto_err`  out  1  sticky; unexpected `tile_done` or `dir_valid`
- `fifo_level`  out  LOG_FIFO_DEPTH+1  current occupancy

## Operation
- State machine:
  - IDLE: on `tile_done`, latch `tile_in` as the header and `dir_count` as `remaining`, zero the pack register and `slot`, then go to HDR.
  - HDR: write the header beat, with `m_last` = (remaining==0). Go to IDLE if remaining==0, else to COLLECT.
  - COLLECT: on each `dir_valid`, place `dir_in` at pack[slot*2*NUM_DIR_BLOCK +: 2*NUM_DIR_BLOCK] and decrement `remaining`.
    - If slot==DPB-1 or remaining reaches 0: write the beat, `m_last` = (remaining after decrement ==0), clear the pack register, set slot=0.
    - Otherwise slot++.
    - Go to IDLE after the write carrying last.
- A partial final beat is zero-padded in its unused upper slots.
- Beats per tile = 1 + ceil(dir_count/DPB).
- FIFO write rule:
  - A write is accepted only if level < FIFO_DEPTH, judged at the start of the cycle. A same-cycle read does not make room.
  - A rejected write is dropped and sets `overflow`. The FSM advances regardless, so tile framing stays intact apart from missing beats.
- FIFO read occurs when `m_valid` && `m_ready`. Simultaneous read and write leave the level unchanged. The pointers wrap modulo FIFO_DEPTH.
- `proto_err` is set by:
  - `tile_done` in any state other than IDLE (the pulse is otherwise ignored);
  - `dir_valid` in IDLE or HDR (the word is discarded).
- `clear` zeroes `overflow` and `proto_err` only; it does not affect FIFO contents or state. If `clear` and a new error coincide, the error wins (flag stays 1).
- `dir_count` values ≥ 2^32 are not possible. The count is used at full 32-bit width.

## Timing
- Reset values: state=IDLE, FIFO empty, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `overflow`=0, `proto_err`=0, `fifo_level`=0, pack register 0.
- Asserting reset mid-tile discards all buffered beats and partial packing immediately (asynchronous).
- `tile_done` is sampled at edge t. The header is written at edge t+1, so `m_valid` is high during cycle t+1 to t+2 when the FIFO was empty.
- A `dir_valid` completing a beat at edge t makes that beat visible at the head one cycle later if the FIFO was empty.
- `dir_valid` pulses may arrive every cycle (one every 3 cycles is typical). There is no internal throughput limit.
- `m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- `busy` rises the cycle after `tile_done` and falls the cycle after the last beat is written.

## Test plan
- **Zero directions:** `tile_done` with dir_count=0 and tile_in=pattern A, `m_ready`=1 → exactly one beat, data=A, `m_last`=1, `busy` back to 0 after 1 cycle.
- **Full packing:** dir_count=8, words D0..D7 at one per 3 cycles → beats: header, {D3,D2,D1,D0}, {D7..D4} with last=1; 3 beats total.
- **Partial beat:** dir_count=5, words D0..D4 → the third beat = {0,0,0,D4}, last=1; the earlier beats' last=0.
- **Back-pressure/overflow:** FIFO_DEPTH=4, `m_ready`=0, dir_count=20 (6 beats) → 4 beats stored, `overflow`=1, `fifo_level`=4. Drain → 4 beats received, no `m_last`. `clear` → `overflow`=0.
- **Protocol error:** second `tile_done` during COLLECT → `proto_err`=1 and the current tile completes unchanged. `dir_valid` in IDLE → `proto_err`=1 and no beat is written.
- **Reset mid-tile:** assert `rst` after 2 of 8 direction words → all outputs at reset values immediately. A following tile with dir_count=4 packs correctly into 2 beats.
